// File: rtl/spu_wb_collector.sv
// rtl/spu_wb_collector.sv - dual-pipe writeback collector: in-order FIFO of retire records with stall hint and drop counting
// Optional build macro: SPU_WB_SEQNUM_EN adds a 16-bit sequence tag to every record.
module spu_wb_collector #(
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 16,
  parameter int STALL_TH = 4,
`ifdef SPU_WB_SEQNUM_EN
  localparam int RECW    = DATA_W + 24,
`else
  localparam int RECW    = DATA_W + 8,
`endif
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid_ep,
  input  logic [6:0]        wb_rt_addr_ep,
  input  logic [DATA_W-1:0] wb_data_ep,
  input  logic              wb_valid_op,
  input  logic [6:0]        wb_rt_addr_op,
  input  logic [DATA_W-1:0] wb_data_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RECW-1:0]   out_rec,
  output logic [CW-1:0]     count,
  output logic              stall_issue,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [RECW-1:0] mem_q [DEPTH];

  logic            pop;
  logic [CW-1:0]   space;
  logic            acc_ep, acc_op;
  logic [1:0]      n_push, n_drop;
  logic [16:0]     drop_sum;
  logic [AW-1:0]   wr_ptr_op;
  logic [RECW-1:0] rec_ep, rec_op;
`ifdef SPU_WB_SEQNUM_EN
  logic [15:0]     seq_q, seq_d;
`endif

  // Admission: the same-cycle pop frees a slot; even pipe claims space before odd.
  always_comb begin
    pop        = (count_q != '0) & out_ready;
    space      = CW'(DEPTH) - count_q + CW'(pop);
    acc_ep     = wb_valid_ep & (space >= CW'(1));
    acc_op     = wb_valid_op & (space >= (acc_ep ? CW'(2) : CW'(1)));
    n_push     = {1'b0, acc_ep} + {1'b0, acc_op};
    n_drop     = {1'b0, wb_valid_ep & ~acc_ep} + {1'b0, wb_valid_op & ~acc_op};
    wr_ptr_op  = wr_ptr_q + AW'(acc_ep);
    wr_ptr_d   = wr_ptr_q + AW'(n_push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(n_push) - CW'(pop);
    overflow_d = overflow_q | (n_drop != 2'd0);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`ifdef SPU_WB_SEQNUM_EN
    seq_d      = seq_q + 16'(n_push);
    rec_ep     = {1'b0, seq_q, wb_rt_addr_ep, wb_data_ep};
    rec_op     = {1'b1, seq_q + 16'(acc_ep), wb_rt_addr_op, wb_data_op};
`else
    rec_ep     = {1'b0, wb_rt_addr_ep, wb_data_ep};
    rec_op     = {1'b1, wb_rt_addr_op, wb_data_op};
`endif
  end

  // Control state: pointers, occupancy and drop bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef SPU_WB_SEQNUM_EN
  // Sequence tag counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seq_q <= '0;
    else      seq_q <= seq_d;
  end
`endif

  // Record storage; contents are meaningless outside the occupied window, so no reset.
  always_ff @(posedge clk) begin
    if (acc_ep) mem_q[wr_ptr_q]  <= rec_ep;
    if (acc_op) mem_q[wr_ptr_op] <= rec_op;
  end

  assign out_valid   = (count_q != '0);
  assign out_rec     = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign stall_issue = (CW'(DEPTH) - count_q) <= CW'(STALL_TH);
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_spu_wb_collector.sv
// tb/tb_spu_wb_collector.sv - scoreboard bench for spu_wb_collector with a queue-based reference model
module tb_spu_wb_collector;
  localparam int DATA_W   = 128;
  localparam int DEPTH    = 16;
  localparam int STALL_TH = 4;
`ifdef SPU_WB_SEQNUM_EN
  localparam int RECW     = DATA_W + 24;
`else
  localparam int RECW     = DATA_W + 8;
`endif
  localparam int CW       = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wb_valid_ep = 1'b0;
  logic [6:0]        wb_rt_addr_ep = '0;
  logic [DATA_W-1:0] wb_data_ep = '0;
  logic              wb_valid_op = 1'b0;
  logic [6:0]        wb_rt_addr_op = '0;
  logic [DATA_W-1:0] wb_data_op = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [RECW-1:0]   out_rec;
  logic [CW-1:0]     count;
  logic              stall_issue;
  logic              overflow;
  logic [15:0]       drop_cnt;

  always #5 clk = ~clk;

  spu_wb_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STALL_TH(STALL_TH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid_ep(wb_valid_ep), .wb_rt_addr_ep(wb_rt_addr_ep), .wb_data_ep(wb_data_ep),
    .wb_valid_op(wb_valid_op), .wb_rt_addr_op(wb_rt_addr_op), .wb_data_op(wb_data_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .count(count), .stall_issue(stall_issue), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: expected retire records in order, plus drop bookkeeping.
  logic [RECW-1:0] exp_q [$];
  int  model_drop = 0;
  bit  model_ovf  = 1'b0;
`ifdef SPU_WB_SEQNUM_EN
  logic [15:0] model_seq = '0;
`endif

  // Expected observable state for the cycle currently being driven.
  bit snap_valid = 1'b0;
  int snap_count = 0;
  int snap_drop  = 0;
  bit snap_ovf   = 1'b0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic push_exp(input bit pid, input logic [6:0] rt, input logic [DATA_W-1:0] d);
`ifdef SPU_WB_SEQNUM_EN
    exp_q.push_back({pid, model_seq, rt, d});
    model_seq = model_seq + 16'd1;
`else
    exp_q.push_back({pid, rt, d});
`endif
  endtask

  // Drive one cycle (called just after a rising edge) and update the model.
  task automatic step(input bit ve, input logic [6:0] re, input logic [DATA_W-1:0] de,
                      input bit vo, input logic [6:0] ro, input logic [DATA_W-1:0] dd,
                      input bit rdy);
    int occ;
    int room;
    int drops;
    bit pe;
    bit po;
    occ        = exp_q.size();
    snap_count = occ;
    snap_drop  = model_drop;
    snap_ovf   = model_ovf;
    snap_valid = 1'b1;
    wb_valid_ep = ve; wb_rt_addr_ep = re; wb_data_ep = de;
    wb_valid_op = vo; wb_rt_addr_op = ro; wb_data_op = dd;
    out_ready   = rdy;
    room = DEPTH - occ + ((occ != 0 && rdy) ? 1 : 0);
    pe = ve && (room >= 1);
    if (pe) room = room - 1;
    po = vo && (room >= 1);
    if (pe) push_exp(1'b0, re, de);
    if (po) push_exp(1'b1, ro, dd);
    drops = ((ve && !pe) ? 1 : 0) + ((vo && !po) ? 1 : 0);
    model_drop = (model_drop + drops > 65535) ? 65535 : model_drop + drops;
    if (drops != 0) model_ovf = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 7'd0, '0, 1'b0, 7'd0, '0, rdy);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares status against the snapshot and retired records against the model queue.
  always @(negedge clk) begin
    if (rst && snap_valid) begin
      chk("count", count, snap_count);
      chk("out_valid", out_valid, snap_count != 0);
      chk("stall_issue", stall_issue, (DEPTH - snap_count) <= STALL_TH);
      chk("drop_cnt", drop_cnt, snap_drop);
      chk("overflow", overflow, snap_ovf);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL pop_with_no_expected_record: got out_rec 0x%0h at %0t", out_rec, $time);
        end else begin
          chk("out_rec", out_rec, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] d1;
    int rprob;
    d1 = '0;
    d1[0] = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single even write, popped the following cycle.
    step(1'b1, 7'h05, d1, 1'b0, 7'd0, '0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Dual write to the same register, held then drained.
    step(1'b1, 7'h03, rnd_data(), 1'b1, 7'h03, rnd_data(), 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill with dual writes, then overflow by two.
    for (int i = 0; i < 9; i++)
      step(1'b1, 7'($urandom), rnd_data(), 1'b1, 7'($urandom), rnd_data(), 1'b0);
    idle(1'b0);

    // One pop to count 15, then dual write with simultaneous pop.
    idle(1'b1);
    step(1'b1, 7'h11, rnd_data(), 1'b1, 7'h22, rnd_data(), 1'b1);
    idle(1'b0);

    // Drain to 9 entries, then asynchronous reset mid-cycle.
    repeat (7) idle(1'b1);
    idle(1'b0);
    #2;
    snap_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    chk("arst_stall", stall_issue, 0);
    exp_q.delete();
    model_drop = 0;
    model_ovf  = 1'b0;
`ifdef SPU_WB_SEQNUM_EN
    model_seq  = '0;
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b1);
    idle(1'b0);

    // Tag sequence through three dual writes (tags checked when the macro is enabled).
    repeat (3) step(1'b1, 7'($urandom), rnd_data(), 1'b1, 7'($urandom), rnd_data(), 1'b0);
    repeat (6) idle(1'b1);

    // Randomized traffic with varying consumer throughput.
    rprob = 50;
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] re;
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: rprob = 15;
          1: rprob = 50;
          default: rprob = 95;
        endcase
      end
      re = 7'($urandom);
      step($urandom_range(0, 99) < 65, re, rnd_data(),
           $urandom_range(0, 99) < 55, ($urandom_range(0, 9) == 0) ? re : 7'($urandom), rnd_data(),
           $urandom_range(0, 99) < rprob);
    end

    // Drain with a bounded cycle budget.
    for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) idle(1'b1);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d records still expected", exp_q.size());
    end
    idle(1'b1);
    snap_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
